fpga_cmd_spi_tx: RTL and testbench
==================================

// Module: fpga_cmd_spi_tx
// PURPOSE
//  SPI command initiator: the transmitting end of the FPGA configuration SPI link (spck/mosi/ncs).
//  Serialises 16-bit command words {op[3:0], 4'b0000, data[7:0]}, MSB first.
//  Used by relay/test logic to configure a second FPGA, and as a bus-accurate driver for the config receiver.
//  Far-end receiver timing:
//   - shifts on rising spck while ncs is low;
//   - latches the command on rising ncs (op 4'b0001 = SET_CONFREG, 4'b0010 = SET_DIVISOR).
// PARAMETERS
//  CLK_DIV   4  ck_1356meg cycles per spck half-period (>=1)
//  CS_SETUP  2  cycles with ncs low before the first spck rising edge (>=1)
//  CS_HOLD   2  cycles with ncs low after the last spck falling edge (>=1)
//  IDLE_GAP  2  minimum cycles with ncs high between frames (>=1)
// PORTS
//  ck_1356meg  in   1   sole clock; all logic on posedge
//  nreset      in   1   synchronous, active-low reset
//  cmd_valid   in   1   command request
//  cmd_ready   out  1   block can accept a command (IDLE state only)
//  cmd_op      in   4   opcode, sampled on handshake
//  cmd_data    in   8   payload, sampled on handshake
//  spck        out  1   SPI clock, idles low
//  mosi        out  1   serial data, MSB first
//  ncs         out  1   chip select, active low
//  miso        in   1   serial return data (used only with readback)
//  busy        out  1   high from handshake until end of GAP
//  done        out  1   one-cycle pulse, coincident with the ncs rising edge
//  rx_word     out  16  word captured from miso (readback)
// BEHAVIOUR
//  Reset (nreset low at a clock edge): ncs=1, spck=0, mosi=0, cmd_ready=0, busy=0, done=0, rx_word=0, FSM=IDLE.
//   - cmd_ready rises the first cycle after nreset is sampled high.
//   - Reset mid-frame aborts the frame immediately; the far end may latch a partial word, so software reissues it.
//  Handshake: accept when cmd_valid & cmd_ready at an edge; op and data are registered into a 16-bit shift register.
//   - cmd_ready drops the same edge and is low for the whole frame and gap; cmd_valid while not ready is ignored.
//  FSM: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE
//   - IDLE: ncs=1, spck=0, cmd_ready=1. On handshake: ncs<=0, mosi<=word[15], busy<=1, go to SETUP.
//   - SETUP: CS_SETUP cycles, spck=0, then SHIFT.
//   - SHIFT: 16 bits; each bit is CLK_DIV cycles spck=0 followed by CLK_DIV cycles spck=1.
//     mosi changes only on the spck falling edge (mode 0), so it is stable around every rising edge.
//     A 4-bit bit counter plus a divider counter track position.
//     After the 16th high phase: spck<=0, go to HOLD; mosi holds the last bit.
//   - HOLD: CS_HOLD cycles, then ncs<=1, done<=1 (one cycle), mosi<=0, go to GAP.
//   - GAP: IDLE_GAP cycles with ncs=1, then IDLE; busy clears on the GAP->IDLE edge.
//  Timing:
//   - ncs low for exactly CS_SETUP + 32*CLK_DIV + CS_HOLD cycles (defaults: 132).
//   - Accept-to-next-ready: that count + IDLE_GAP + 1 cycles (defaults: 135).
//   - Exactly 16 spck rising edges per frame; no spck edge while ncs is high.
//  Counters: the divider wraps at CLK_DIV-1; the bit counter wraps 15->0 only on HOLD entry.
//   - Parameters are not range-checked at run time.
// CONFIGURATION
//  FPGA_CMD_SPI_TX_READBACK_EN defined:
//   - miso is sampled on each spck rising edge (the cycle spck goes 1) into rx_word, shifted in MSB first.
//   - rx_word updates only on done; it holds its value between frames.
//  FPGA_CMD_SPI_TX_READBACK_EN undefined:
//   - miso is ignored; rx_word is tied to 16'h0000; no capture register is synthesised.
// TESTING
//  1. op=1, data=8'hA5, defaults -> mosi at the 16 rising spck edges = 16'h10A5; ncs low 132 cycles; done pulses once.
//     The receiver model then has conf_word=8'hA5.
//  2. cmd_valid held with op=2, data=8'h3C for two commands -> two frames; divisor=8'h3C.
//     ncs high >= IDLE_GAP cycles between frames; second accept occurs 135 cycles after the first.
//  3. cmd_valid pulsed mid-frame -> cmd_ready=0, no acceptance; frame bits unchanged; no extra frame.
//  4. nreset low after 7 spck rising edges -> next edge: ncs=1, spck=0, mosi=0, busy=0.
//     cmd_ready=0 until one cycle after release.
//  5. READBACK_EN: miso driven from a 16'hBEEF shift model -> rx_word=16'hBEEF in the done cycle.
//     Without the macro, rx_word stays 0.
//  6. CLK_DIV=1, CS_SETUP=1, CS_HOLD=1 -> ncs low 34 cycles; spck toggles every cycle; 16 rising edges.

Source files
------------

// File: rtl/fpga_cmd_spi_tx_if.sv
// Command handshake and SPI link signals for fpga_cmd_spi_tx.
// slave  : the SPI initiator block (accepts commands, drives spck/mosi/ncs).
// master : the command source / link partner (drives commands and miso).
interface fpga_cmd_spi_tx_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic        spck;
  logic        mosi;
  logic        ncs;
  logic        miso;
  logic        busy;
  logic        done;
  logic [15:0] rx_word;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, miso,
    output cmd_ready, spck, mosi, ncs, busy, done, rx_word
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, miso,
    input  cmd_ready, spck, mosi, ncs, busy, done, rx_word
  );
endinterface

// File: rtl/fpga_cmd_spi_tx.sv
// SPI command initiator for the FPGA configuration link.
// Serialises {op[3:0], 4'b0000, data[7:0]} MSB first, SPI mode 0, with
// programmable chip-select setup/hold and inter-frame gap.
// Optional readback of miso into rx_word: define FPGA_CMD_SPI_TX_READBACK_EN.
module fpga_cmd_spi_tx #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int IDLE_GAP = 2
) (
  input  logic               ck_1356meg,
  input  logic               nreset,
  fpga_cmd_spi_tx_if.slave   bus
);

  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
  localparam logic [15:0] GAP_LAST   = 16'(IDLE_GAP - 1);
  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t      state_q, state_nxt;
  logic [15:0] cnt_q, cnt_nxt;
  logic [15:0] div_q, div_nxt;
  logic [3:0]  bit_q, bit_nxt;
  logic [15:0] sh_q, sh_nxt;
  logic        spck_q, spck_nxt;
  logic        mosi_q, mosi_nxt;
  logic        ncs_q, ncs_nxt;
  logic        busy_q, busy_nxt;
  logic        done_q, done_nxt;
  logic        ready_q, ready_nxt;
  logic        rise_evt;

  // Control state and registered link outputs; frame aborts on reset.
  always_ff @(posedge ck_1356meg) begin
    if (!nreset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      spck_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ncs_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      div_q   <= div_nxt;
      bit_q   <= bit_nxt;
      spck_q  <= spck_nxt;
      mosi_q  <= mosi_nxt;
      ncs_q   <= ncs_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      ready_q <= ready_nxt;
    end
  end

  // Command shift register holds data only, so it carries no reset.
  always_ff @(posedge ck_1356meg) begin
    sh_q <= sh_nxt;
  end

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    div_nxt   = div_q;
    bit_nxt   = bit_q;
    sh_nxt    = sh_q;
    spck_nxt  = spck_q;
    mosi_nxt  = mosi_q;
    ncs_nxt   = ncs_q;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
    ready_nxt = ready_q;
    rise_evt  = 1'b0;

    case (state_q)
      S_IDLE: begin
        spck_nxt  = 1'b0;
        ncs_nxt   = 1'b1;
        ready_nxt = 1'b1;
        if (bus.cmd_valid && ready_q) begin
          sh_nxt    = {bus.cmd_op, 4'b0000, bus.cmd_data};
          mosi_nxt  = bus.cmd_op[3];
          ncs_nxt   = 1'b0;
          busy_nxt  = 1'b1;
          ready_nxt = 1'b0;
          cnt_nxt   = '0;
          state_nxt = S_SETUP;
        end
      end

      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_nxt   = '0;
          div_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = S_SHIFT;
        end else begin
          cnt_nxt = cnt_q + 16'd1;
        end
      end

      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_nxt = '0;
          if (!spck_q) begin
            spck_nxt = 1'b1;
            rise_evt = 1'b1;
          end else begin
            spck_nxt = 1'b0;
            if (bit_q == 4'd15) begin
              // Last falling edge: keep the final bit on mosi through HOLD.
              bit_nxt   = '0;
              cnt_nxt   = '0;
              state_nxt = S_HOLD;
            end else begin
              bit_nxt  = bit_q + 4'd1;
              sh_nxt   = {sh_q[14:0], 1'b0};
              mosi_nxt = sh_q[14];
            end
          end
        end else begin
          div_nxt = div_q + 16'd1;
        end
      end

      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          ncs_nxt   = 1'b1;
          done_nxt  = 1'b1;
          mosi_nxt  = 1'b0;
          cnt_nxt   = '0;
          state_nxt = S_GAP;
        end else begin
          cnt_nxt = cnt_q + 16'd1;
        end
      end

      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          busy_nxt  = 1'b0;
          ready_nxt = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt_q + 16'd1;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.spck      = spck_q;
  assign bus.mosi      = mosi_q;
  assign bus.ncs       = ncs_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cmd_ready = ready_q;

`ifdef FPGA_CMD_SPI_TX_READBACK_EN
  logic [15:0] rx_sh_q;
  logic [15:0] rx_word_q;

  // Shift miso in on every spck rise; publish the word with done.
  always_ff @(posedge ck_1356meg) begin
    if (!nreset) begin
      rx_word_q <= '0;
    end else if (done_nxt) begin
      rx_word_q <= rx_sh_q;
    end
    if (rise_evt) begin
      rx_sh_q <= {rx_sh_q[14:0], bus.miso};
    end
  end

  assign bus.rx_word = rx_word_q;
`else
  logic unused_readback;
  assign unused_readback = bus.miso ^ rise_evt;
  assign bus.rx_word     = 16'h0000;
`endif

endmodule

// File: tb/tb_fpga_cmd_spi_tx.sv
// Self-checking bench for fpga_cmd_spi_tx: table-driven frames with a
// scoreboard of expected words, plus hand-written multi-cycle sequences.
module tb_fpga_cmd_spi_tx;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  fpga_cmd_spi_tx_if bus ();
  fpga_cmd_spi_tx_if bus2 ();

  fpga_cmd_spi_tx dut (
    .ck_1356meg (clk),
    .nreset     (nreset),
    .bus        (bus)
  );

  fpga_cmd_spi_tx #(
    .CLK_DIV  (1),
    .CS_SETUP (1),
    .CS_HOLD  (1),
    .IDLE_GAP (2)
  ) dut2 (
    .ck_1356meg (clk),
    .nreset     (nreset),
    .bus        (bus2)
  );

`ifdef FPGA_CMD_SPI_TX_READBACK_EN
  localparam logic [15:0] RX_EXP = 16'hBEEF;
`else
  localparam logic [15:0] RX_EXP = 16'h0000;
`endif

  int checks   = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // cycle counter
  int cyc = 0;
  always @(posedge clk) cyc++;

  // far-end miso shift model: presents 16'hBEEF MSB first, advancing on spck falls
  logic [15:0] miso_pat = 16'hBEEF;
  int fall_cnt = 0;
  always @(negedge bus.spck or posedge bus.ncs) begin
    if (bus.ncs === 1'b1) fall_cnt = 0;
    else fall_cnt = fall_cnt + 1;
  end
  assign bus.miso  = miso_pat[4'(15 - fall_cnt)];
  assign bus2.miso = 1'b0;

  // link monitor / far-end receiver / scoreboard
  logic [15:0] exp_q[$];
  logic [15:0] cap = '0;
  logic [15:0] exp_w;
  int rises = 0, nlow = 0, frames = 0, stray = 0, hi_run = 0, last_hi = 0;
  logic prev_spck = 1'b0, prev_ncs = 1'b1, prev_mosi = 1'b0;
  logic [7:0] conf_word = 8'h00, divisor = 8'h00;

  always @(negedge clk) begin
    if (!nreset) begin
      rises = 0; nlow = 0; cap = '0; stray = 0;
      prev_spck = 1'b0; prev_ncs = 1'b1; prev_mosi = 1'b0;
    end else begin
      if (bus.spck && !prev_spck) begin
        if (bus.ncs) stray++;
        rises++;
        cap = {cap[14:0], bus.mosi};
      end
      if (bus.mosi != prev_mosi && !bus.ncs && !prev_ncs && !(prev_spck && !bus.spck)) stray++;
      if (!bus.ncs) begin
        nlow++;
      end else begin
        hi_run++;
      end
      if (!bus.ncs && prev_ncs) begin
        last_hi = hi_run;
        hi_run  = 0;
      end
      if (bus.ncs && !prev_ncs && rises == 16) begin
        if (cap[15:12] == 4'd1) conf_word = cap[7:0];
        if (cap[15:12] == 4'd2) divisor   = cap[7:0];
      end
      if (bus.done) begin
        frames++;
        check("done_at_ncs_rise", 32'({bus.ncs, prev_ncs}), 32'(2'b10));
        check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        check("frame_word", 32'(cap), 32'(exp_w));
        check("frame_rises", 32'(rises), 32'd16);
        check("frame_ncs_low", 32'(nlow), 32'd132);
        check("frame_stray_edges", 32'(stray), 32'd0);
        check("rx_word_done", 32'(bus.rx_word), 32'(RX_EXP));
        rises = 0; nlow = 0; cap = '0; stray = 0;
      end
      prev_spck = bus.spck;
      prev_ncs  = bus.ncs;
      prev_mosi = bus.mosi;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [7:0] data, input logic [15:0] word);
    int n = 0;
    while (!bus.cmd_ready && n < 500) begin
      tick();
      n++;
    end
    check("send_ready", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
    exp_q.push_back(word);
    tick();
    bus.cmd_valid = 1'b0;
    check("ready_drops_on_accept", 32'({bus.cmd_ready, bus.busy, bus.ncs}), 32'(3'b010));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 500) begin
      tick();
      n++;
    end
    check("idle_reached", 32'({bus.busy, bus.cmd_ready}), 32'(2'b01));
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [7:0]  data;
    logic [15:0] word;
    logic [7:0]  conf;
    logic [7:0]  div;
  } vec_t;

  vec_t vt[5];

  // watchdog
  initial begin
    #400000;
    $display("FAIL watchdog timeout actual=%0d expected=<40000 cycles", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n, nacc, a0, a1, f0;
    int nlow2, rises2, tog2;
    logic [15:0] w2;
    logic p2, done2;

    vt[0] = '{4'h1, 8'hA5, 16'h10A5, 8'hA5, 8'h00};
    vt[1] = '{4'h2, 8'h3C, 16'h203C, 8'hA5, 8'h3C};
    vt[2] = '{4'h1, 8'h00, 16'h1000, 8'h00, 8'h3C};
    vt[3] = '{4'h2, 8'hFF, 16'h20FF, 8'h00, 8'hFF};
    vt[4] = '{4'hF, 8'h5A, 16'hF05A, 8'h00, 8'hFF};

    nreset         = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 4'h0;
    bus.cmd_data   = 8'h00;
    bus2.cmd_valid = 1'b0;
    bus2.cmd_op    = 4'h0;
    bus2.cmd_data  = 8'h00;
    repeat (3) tick();

    // reset state
    check("reset_outputs", 32'({bus.ncs, bus.spck, bus.mosi, bus.cmd_ready, bus.busy, bus.done}),
          32'(6'b100000));
    check("reset_rx_word", 32'(bus.rx_word), 32'd0);
    nreset = 1'b1;
    tick();
    check("ready_after_release", 32'(bus.cmd_ready), 32'd1);

    // table-driven frames
    for (int i = 0; i < 5; i++) begin
      send(vt[i].op, vt[i].data, vt[i].word);
      wait_idle();
      check("rx_conf_word", 32'(conf_word), 32'(vt[i].conf));
      check("rx_divisor", 32'(divisor), 32'(vt[i].div));
      check("rx_word_holds", 32'(bus.rx_word), 32'(RX_EXP));
    end

    // back-to-back commands with cmd_valid held
    bus.cmd_op    = 4'h2;
    bus.cmd_data  = 8'h77;
    exp_q.push_back(16'h2077);
    exp_q.push_back(16'h2077);
    bus.cmd_valid = 1'b1;
    nacc = 0; a0 = 0; a1 = 0;
    for (int i = 0; i < 400 && nacc < 2; i++) begin
      if (bus.cmd_ready) begin
        if (nacc == 0) a0 = cyc;
        else a1 = cyc;
        nacc++;
      end
      tick();
    end
    bus.cmd_valid = 1'b0;
    check("b2b_accepts", 32'(nacc), 32'd2);
    check("b2b_accept_spacing", 32'(a1 - a0), 32'd135);
    wait_idle();
    check("b2b_gap_ncs_high", 32'(last_hi), 32'd3);
    check("b2b_divisor", 32'(divisor), 32'h77);

    // cmd_valid pulsed mid-frame must be ignored
    f0 = frames;
    send(4'h1, 8'h3E, 16'h103E);
    n = 0;
    while (rises < 4 && n < 200) begin tick(); n++; end
    check("midframe_reached", 32'(rises >= 4), 32'd1);
    bus.cmd_op    = 4'h2;
    bus.cmd_data  = 8'h11;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("midframe_not_ready", 32'(bus.cmd_ready), 32'd0);
      tick();
    end
    bus.cmd_valid = 1'b0;
    wait_idle();
    repeat (20) tick();
    check("midframe_single_frame", 32'(frames - f0), 32'd1);
    check("midframe_conf", 32'(conf_word), 32'h3E);
    check("midframe_divisor_kept", 32'(divisor), 32'h77);

    // reset mid-frame after 7 rising edges
    send(4'h2, 8'h99, 16'h2099);
    n = 0;
    while (rises < 7 && n < 200) begin tick(); n++; end
    check("abort_point", 32'(rises), 32'd7);
    nreset = 1'b0;
    tick();
    check("abort_outputs", 32'({bus.ncs, bus.spck, bus.mosi, bus.busy, bus.cmd_ready, bus.done}),
          32'(6'b100000));
    tick();
    check("abort_ready_held_low", 32'(bus.cmd_ready), 32'd0);
    exp_q.delete();
    nreset = 1'b1;
    tick();
    check("abort_ready_after_release", 32'(bus.cmd_ready), 32'd1);
    check("abort_divisor_unchanged", 32'(divisor), 32'h77);

    // fast configuration: CLK_DIV=1, CS_SETUP=1, CS_HOLD=1
    check("fast_ready", 32'(bus2.cmd_ready), 32'd1);
    bus2.cmd_op    = 4'h1;
    bus2.cmd_data  = 8'h5A;
    bus2.cmd_valid = 1'b1;
    exp_q.push_back(16'h105A);
    tick();
    bus2.cmd_valid = 1'b0;
    nlow2 = 0; rises2 = 0; tog2 = 0; w2 = '0; p2 = 1'b0; done2 = 1'b0;
    for (int i = 0; i < 200 && !done2; i++) begin
      if (!bus2.ncs) nlow2++;
      if (bus2.spck != p2) tog2++;
      if (bus2.spck && !p2) begin
        rises2++;
        w2 = {w2[14:0], bus2.mosi};
      end
      p2 = bus2.spck;
      if (bus2.done) done2 = 1'b1;
      else tick();
    end
    check("fast_done", 32'(done2), 32'd1);
    check("fast_ncs_low", 32'(nlow2), 32'd34);
    check("fast_rises", 32'(rises2), 32'd16);
    check("fast_toggles", 32'(tog2), 32'd32);
    exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    check("fast_word", 32'(w2), 32'(exp_w));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
